adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
Linear ADSR envelope generator, one step per audio sample. It sits directly upstream of the sample multiplier and drives that multiplier's gain operand (in2) to form a VCA. Its output is scaled so that full level equals the multiplier's unity gain, 2^(BITSIZE-2). The multiplier returns the product shifted right by BITSIZE-2.

Parameters:
BITSIZE, 16, sample/gain width; must match the multiplier (16 only; 24 is unsupported, matching the multiplier).
FRAC, 8, fractional bits of the internal level accumulator; must be >= 2.

Ports:
lrclk  input  1  sample clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
gate  input  1  note on (1) / off (0); sampled on posedge lrclk.
attack  input  BITSIZE  unsigned level increment per sample in ATTACK, in 2^-FRAC output LSBs; 0 = instant.
decay  input  BITSIZE  unsigned decrement per sample in DECAY; 0 = instant.
sustain  input  BITSIZE  unsigned sustain level in output LSBs; values > 2^(BITSIZE-2) are clamped to 2^(BITSIZE-2).
release  input  BITSIZE  unsigned decrement per sample in RELEASE; 0 = instant.
out  output  BITSIZE  signed envelope, always in 0 .. 2^(BITSIZE-2).
active  output  1  1 whenever state != IDLE.

Behaviour:
- Internal registers:
  - level: unsigned, BITSIZE+FRAC bits.
  - PEAK = 2^(BITSIZE-2) << FRAC.
  - SUS = min(sustain, 2^(BITSIZE-2)) << FRAC.
  - gate_q: previous gate.
  - state: 3 bits.
- out = level >> FRAC, zero-extended. It is driven straight from the level register, with no extra latency.
- Reset (asynchronous, at any time including mid-envelope) clears level, gate_q and out to 0, sets state to IDLE and active to 0.
- A rising edge is gate=1 and gate_q=0 at an edge. In any state it moves to ATTACK with level held that edge (retrigger; no restart from 0). The first increment happens on the next edge.
- A rising edge has priority over every other transition.
- IDLE: level=0. Leaves only on a rising edge.
- ATTACK:
  - gate=0: go to RELEASE, level held.
  - Else if attack=0 or level+attack >= PEAK: level=PEAK, go to DECAY.
  - Else level += attack.
- DECAY:
  - gate=0: go to RELEASE, level held.
  - Else if decay=0 or level <= SUS+decay: level=SUS, go to SUSTAIN. This includes jumping up when level < SUS.
  - Else level -= decay.
- SUSTAIN:
  - gate=0: go to RELEASE, level held.
  - Else level=SUS, so a live change on sustain is followed on the next edge.
- RELEASE:
  - Rising edge: go to ATTACK.
  - Else if release=0 or level <= release: level=0, go to IDLE.
  - Else level -= release.
- Arithmetic limits:
  - level never exceeds PEAK and never underflows.
  - The intermediate sum level+attack is computed at BITSIZE+FRAC+1 bits, so it cannot wrap.
- The input rates are sampled each edge. Changing a rate mid-phase takes effect on the next step.
- active mirrors the registered state: it rises on the edge entering ATTACK and falls on the edge entering IDLE.

Test Plan:
1. BITSIZE=16, FRAC=8, attack=65535, gate rises before edge 0.
   - Edge 0: state ATTACK, out=0.
   - Edge 64: out=16383.
   - Edge 65: out=16384, state DECAY.
2. attack=0, decay=1024, sustain=8192, gate held high.
   - Edge 1: out=16384.
   - out then falls 4 LSB per edge.
   - Edge 2049: out=8192, state SUSTAIN. out stays 8192.
   - Change sustain to 4000: out=4000 on the next edge.
3. From SUSTAIN at out=8192, release=2048, gate falls.
   - Next edge: RELEASE, out=8192.
   - out then drops 8 per edge.
   - After 1024 further edges: out=0, state IDLE, active=0.
4. Retrigger in RELEASE at out=5000, attack=256.
   - Rising edge: ATTACK, out=5000.
   - Next edge: out=5001. Does not return to 0.
5. Boundaries:
   - sustain=60000 is clamped: SUSTAIN out=16384.
   - release=0: gate fall then one edge gives out=0, IDLE.
   - Gate pulse of one sample during ATTACK: ATTACK then RELEASE, with level held on the transition edge.
6. Assert reset asynchronously mid-ATTACK (out about 9000).
   - out=0 and active=0 immediately, without waiting for a clock edge.
   - After release of reset with gate still high and gate_q=0: ATTACK restarts from 0 on the first edge.

Source files
------------

// File: rtl/adsr_envelope.sv
// Linear ADSR envelope generator, one step per audio sample (lrclk).
// Output is scaled so full level equals the downstream multiplier's unity gain, 2^(BITSIZE-2).
module adsr_envelope #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = 8
) (
  input  logic                      lrclk,
  input  logic                      reset,
  input  logic                      gate,
  input  logic        [BITSIZE-1:0] attack,
  input  logic        [BITSIZE-1:0] decay,
  input  logic        [BITSIZE-1:0] sustain,
  input  logic        [BITSIZE-1:0] release_rate,
  output logic signed [BITSIZE-1:0] out,
  output logic                      active
);

  localparam int unsigned LW = BITSIZE + FRAC;
  localparam int unsigned SW = LW + 1;
  localparam logic [BITSIZE-1:0] UNITY = BITSIZE'(1) << (BITSIZE - 2);
  localparam logic [LW-1:0]      PEAK  = LW'(UNITY) << FRAC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_next;
  logic            gate_q;

  logic            rise;
  logic [BITSIZE-1:0] sus_clamp;
  logic [LW-1:0]   sus_level;
  logic [SW-1:0]   att_sum;
  logic [SW-1:0]   dec_floor;
  logic [SW-1:0]   level_wide;

  // Rate arithmetic, widened by one bit so sums cannot wrap
  always_comb begin
    rise       = gate & ~gate_q;
    sus_clamp  = (sustain > UNITY) ? UNITY : sustain;
    sus_level  = {sus_clamp, {FRAC{1'b0}}};
    level_wide = SW'(level);
    att_sum    = level_wide + SW'(attack);
    dec_floor  = SW'(sus_level) + SW'(decay);
  end

  // Next-state / next-level; a rising gate retriggers from the held level
  always_comb begin
    state_next = state;
    level_next = level;
    if (rise) begin
      state_next = ST_ATTACK;
    end else begin
      case (state)
        ST_IDLE: begin
          level_next = '0;
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_next = ST_RELEASE;
          end else if ((attack == '0) || (att_sum >= SW'(PEAK))) begin
            level_next = PEAK;
            state_next = ST_DECAY;
          end else begin
            level_next = att_sum[LW-1:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_next = ST_RELEASE;
          end else if ((decay == '0) || (level_wide <= dec_floor)) begin
            level_next = sus_level;
            state_next = ST_SUSTAIN;
          end else begin
            level_next = level - LW'(decay);
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            state_next = ST_RELEASE;
          end else begin
            level_next = sus_level;
          end
        end
        ST_RELEASE: begin
          if ((release_rate == '0) || (level <= LW'(release_rate))) begin
            level_next = '0;
            state_next = ST_IDLE;
          end else begin
            level_next = level - LW'(release_rate);
          end
        end
        default: begin
          level_next = '0;
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge lrclk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      level  <= '0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      gate_q <= gate;
    end
  end

  // Both outputs come straight from registers, so async reset clears them at once
  assign out    = $signed(level[LW-1:FRAC]);
  assign active = (state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: a behavioural model predicts out/active per sample.
module tb_adsr_envelope;

  localparam int unsigned BITSIZE = 16;
  localparam int unsigned FRAC    = 8;
  localparam longint     UNITY   = 16384;
  localparam longint     PEAK    = UNITY * 256;

  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

  logic                      lrclk = 1'b0;
  logic                      reset = 1'b1;
  logic                      gate  = 1'b0;
  logic        [BITSIZE-1:0] attack = '0;
  logic        [BITSIZE-1:0] decay = '0;
  logic        [BITSIZE-1:0] sustain = '0;
  logic        [BITSIZE-1:0] release_rate = '0;
  logic signed [BITSIZE-1:0] out;
  logic                      active;

  adsr_envelope #(.BITSIZE(BITSIZE), .FRAC(FRAC)) dut (
    .lrclk        (lrclk),
    .reset        (reset),
    .gate         (gate),
    .attack       (attack),
    .decay        (decay),
    .sustain      (sustain),
    .release_rate (release_rate),
    .out          (out),
    .active       (active)
  );

  always #5 lrclk = ~lrclk;

  typedef struct {
    string tag;
    int    out;
    int    act;
  } exp_t;

  exp_t   sb[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint m_level = 0;
  int     m_state = M_IDLE;
  bit     m_gq    = 1'b0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_state = M_IDLE;
    m_gq    = 1'b0;
  endtask

  // Reference step: what one lrclk edge does to the envelope
  task automatic model_step();
    longint a, d, s, r;
    a = longint'(attack);
    d = longint'(decay);
    r = longint'(release_rate);
    s = (longint'(sustain) > UNITY) ? UNITY * 256 : longint'(sustain) * 256;
    if (gate && !m_gq) begin
      m_state = M_ATT;
    end else begin
      case (m_state)
        M_IDLE: m_level = 0;
        M_ATT:
          if (!gate) m_state = M_REL;
          else if (a == 0 || m_level + a >= PEAK) begin m_level = PEAK; m_state = M_DEC; end
          else m_level += a;
        M_DEC:
          if (!gate) m_state = M_REL;
          else if (d == 0 || m_level <= s + d) begin m_level = s; m_state = M_SUS; end
          else m_level -= d;
        M_SUS:
          if (!gate) m_state = M_REL;
          else m_level = s;
        default:
          if (r == 0 || m_level <= r) begin m_level = 0; m_state = M_IDLE; end
          else m_level -= r;
      endcase
    end
    m_gq = gate;
  endtask

  // Predict, push, clock, then pop and compare
  task automatic tick(input string tag);
    exp_t e;
    model_step();
    sb.push_back('{tag, int'(m_level / 256), (m_state != M_IDLE) ? 1 : 0});
    @(posedge lrclk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_out"}, 32'(out), e.out);
    check({e.tag, "_act"}, 32'(active), e.act);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_out", 32'(out), 0);
    check("rst_act", 32'(active), 0);
    reset = 1'b0;
    model_reset();

    // Full-scale attack reaching peak
    attack = 16'd65535; decay = 16'd1024; sustain = 16'd8192; gate = 1'b1;
    for (int i = 0; i <= 65; i++) begin
      tick("t1");
      if (i == 0)  check("t1_e0", 32'(out), 0);
      if (i == 64) check("t1_e64", 32'(out), 16383);
      if (i == 65) check("t1_e65", 32'(out), 16384);
    end
    gate = 1'b0; release_rate = 16'd0;
    tick("to_rel");
    tick("rel0");
    check("rel0_out", 32'(out), 0);
    check("rel0_act", 32'(active), 0);

    // Instant attack, slow decay to sustain, live sustain change
    attack = 16'd0; decay = 16'd1024; sustain = 16'd8192; gate = 1'b1;
    for (int i = 0; i <= 2049; i++) begin
      tick("t2");
      if (i == 1)    check("t2_e1", 32'(out), 16384);
      if (i == 2)    check("t2_e2", 32'(out), 16380);
      if (i == 2049) check("t2_e2049", 32'(out), 8192);
    end
    for (int i = 0; i < 4; i++) tick("t2_hold");
    check("t2_hold", 32'(out), 8192);
    sustain = 16'd4000;
    tick("t2_live");
    check("t2_live", 32'(out), 4000);
    sustain = 16'd60000;
    tick("t5_clamp");
    check("t5_clamp", 32'(out), 16384);
    sustain = 16'd8192;
    tick("t2_back");

    // Linear release to idle
    release_rate = 16'd2048; gate = 1'b0;
    tick("t3_first");
    check("t3_first", 32'(out), 8192);
    for (int i = 1; i <= 1024; i++) begin
      tick("t3");
      if (i == 1) check("t3_step", 32'(out), 8184);
    end
    check("t3_end_out", 32'(out), 0);
    check("t3_end_act", 32'(active), 0);

    // Retrigger during release keeps the level
    attack = 16'd0; decay = 16'd0; sustain = 16'd5000; gate = 1'b1;
    tick("t4_a"); tick("t4_b"); tick("t4_c");
    release_rate = 16'd256; gate = 1'b0;
    tick("t4_rel");
    gate = 1'b1;
    tick("t4_retrig");
    check("t4_retrig", 32'(out), 5000);
    attack = 16'd256;
    tick("t4_inc");
    check("t4_inc", 32'(out), 5001);

    // One-sample gate drop during attack
    gate = 1'b0;
    tick("t5_pulse");
    check("t5_pulse", 32'(out), 5001);
    gate = 1'b1;
    tick("t5_re");
    tick("t5_re2");

    // Asynchronous reset mid-attack
    gate = 1'b0; release_rate = 16'd0;
    tick("t6_r"); tick("t6_i");
    attack = 16'd65535; gate = 1'b1;
    for (int i = 0; i <= 35; i++) tick("t6_att");
    check("t6_pre", 32'(out), 8959);
    #2 reset = 1'b1;
    #1;
    check("t6_async_out", 32'(out), 0);
    check("t6_async_act", 32'(active), 0);
    model_reset();
    #2 reset = 1'b0;
    tick("t6_restart");
    check("t6_restart", 32'(out), 0);
    tick("t6_step");
    check("t6_step", 32'(out), 255);

    // Random gate and rate activity
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) gate = ~gate;
      if ($urandom_range(0, 7) == 0) begin
        attack       = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40000));
        decay        = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
        sustain      = 16'($urandom_range(0, 65535));
        release_rate = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 20000));
      end
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
